// File: rtl/fpu_shift_pkg.sv
// Shared types and stage-partitioning helpers for the pipelined FPU barrel shifter.
package fpu_shift_pkg;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_ROR = 2'b11
  } sh_mode_e;

  // Mux levels are split evenly across stages; earlier stages absorb the remainder.
  function automatic int stage_levels(input int shw, input int stages, input int idx);
    return (shw / stages) + ((idx < (shw % stages)) ? 1 : 0);
  endfunction

  function automatic int first_level(input int shw, input int stages, input int idx);
    int f;
    f = 0;
    for (int i = 0; i < idx; i++) f += stage_levels(shw, stages, i);
    return f;
  endfunction

endpackage

// File: rtl/fpu_shift_stage.sv
// One pipeline stage: applies shift levels FIRST..FIRST+LEVELS-1 and registers the result.
// Sticky accumulation is built only when FPU_SHIFTER_STICKY_EN is defined.
module fpu_shift_stage
  import fpu_shift_pkg::*;
#(
  parameter int WIDTH  = 46,
  parameter int SHW    = 6,
  parameter int FIRST  = 0,
  parameter int LEVELS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_data,
  input  sh_mode_e         prev_mode,
  input  logic [SHW-1:0]   prev_amt,
`ifdef FPU_SHIFTER_STICKY_EN
  input  logic             prev_sticky,
  output logic             sticky,
`endif
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output sh_mode_e         mode,
  output logic [SHW-1:0]   amt
);

  logic [WIDTH-1:0] nxt_data;
`ifdef FPU_SHIFTER_STICKY_EN
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
  logic nxt_sticky;
`endif

  // Level k shifts by 2^k; shifts of 2^k >= WIDTH saturate rather than wrap,
  // while rotation is periodic so ROR naturally yields n mod WIDTH.
  always_comb begin
    nxt_data = prev_data;
`ifdef FPU_SHIFTER_STICKY_EN
    nxt_sticky = prev_sticky;
`endif
    for (int k = FIRST; k < FIRST + LEVELS; k++) begin
      if (prev_amt[k]) begin
`ifdef FPU_SHIFTER_STICKY_EN
        if (prev_mode == SH_SRL || prev_mode == SH_SRA)
          nxt_sticky = nxt_sticky | (|(nxt_data & ~(ONES << (2**k))));
`endif
        unique case (prev_mode)
          SH_SLL: nxt_data = nxt_data << (2**k);
          SH_SRL: nxt_data = nxt_data >> (2**k);
          SH_SRA: nxt_data = $signed(nxt_data) >>> (2**k);
          SH_ROR: nxt_data = (nxt_data >> ((2**k) % WIDTH)) |
                             (nxt_data << (WIDTH - ((2**k) % WIDTH)));
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      mode  <= SH_SLL;
      amt   <= '0;
    end else if (adv) begin
      valid <= prev_valid;
      data  <= nxt_data;
      mode  <= prev_mode;
      amt   <= prev_amt;
    end
  end

`ifdef FPU_SHIFTER_STICKY_EN
  always_ff @(posedge clk) begin
    if (rst)      sticky <= 1'b0;
    else if (adv) sticky <= nxt_sticky;
  end
`endif

endmodule

// File: rtl/fpu_shifter_pipe.sv
// Parametrised pipelined barrel shifter (SLL/SRL/SRA/ROR) with valid/ready on both sides.
// Define FPU_SHIFTER_STICKY_EN to build the right-shift sticky output; otherwise out_sticky is 0.
module fpu_shifter_pipe
  import fpu_shift_pkg::*;
#(
  parameter int WIDTH  = 46,
  parameter int SHW    = 6,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  input  logic [SHW-1:0]   in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sticky
);

  logic                 adv;
  logic [STAGES:0]      vld;
  logic [WIDTH-1:0]     dat  [STAGES+1];
  sh_mode_e             mde  [STAGES+1];
  logic [SHW-1:0]       amt  [STAGES+1];
`ifdef FPU_SHIFTER_STICKY_EN
  logic [STAGES:0]      stk;
  assign stk[0] = 1'b0;
`endif

  // The whole pipe moves together; a stalled result freezes every stage.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  assign vld[0] = in_valid;
  assign dat[0] = in_data;
  assign mde[0] = sh_mode_e'(in_mode);
  assign amt[0] = in_amt;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    fpu_shift_stage #(
      .WIDTH (WIDTH),
      .SHW   (SHW),
      .FIRST (first_level(SHW, STAGES, s)),
      .LEVELS(stage_levels(SHW, STAGES, s))
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .adv        (adv),
      .prev_valid (vld[s]),
      .prev_data  (dat[s]),
      .prev_mode  (mde[s]),
      .prev_amt   (amt[s]),
`ifdef FPU_SHIFTER_STICKY_EN
      .prev_sticky(stk[s]),
      .sticky     (stk[s+1]),
`endif
      .valid      (vld[s+1]),
      .data       (dat[s+1]),
      .mode       (mde[s+1]),
      .amt        (amt[s+1])
    );
  end

  assign out_valid = vld[STAGES];
  assign out_data  = dat[STAGES];
`ifdef FPU_SHIFTER_STICKY_EN
  assign out_sticky = stk[STAGES];
`else
  assign out_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_shifter_pipe.sv
// Scoreboard bench for fpu_shifter_pipe: driver pushes reference results, monitor pops on output transfers.
// Honours FPU_SHIFTER_STICKY_EN for the expected sticky value.
module tb_fpu_shifter_pipe;

  localparam int WIDTH  = 46;
  localparam int SHW    = 6;
  localparam int STAGES = 2;
`ifdef FPU_SHIFTER_STICKY_EN
  localparam bit STK_EN = 1'b1;
`else
  localparam bit STK_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_mode;
  logic [SHW-1:0]   in_amt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_sticky;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             sticky;
    int               tin;
    bit               chk_lat;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nfail = 0;
  int   cyc = 0;
  bit   bp_en = 1'b0;
  bit   lat_en = 1'b1;

  fpu_shifter_pipe #(.WIDTH(WIDTH), .SHW(SHW), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sticky(out_sticky)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain arithmetic definitions of each mode, sticky as OR of the low n bits of A.
  function automatic logic [WIDTH:0] refShift(input logic [WIDTH-1:0] a, input logic [1:0] mode,
                                              input int n);
    logic [WIDTH-1:0]   r;
    logic               s;
    logic [2*WIDTH-1:0] aa;
    logic [63:0]        lowmask;
    s = 1'b0;
    r = a;
    lowmask = (64'd1 << n) - 64'd1;
    case (mode)
      2'd0: r = (n >= WIDTH) ? '0 : a << n;
      2'd1: begin
        r = (n >= WIDTH) ? '0 : a >> n;
        s = (n >= WIDTH) ? |a : |(a & lowmask[WIDTH-1:0]);
      end
      2'd2: begin
        for (int i = 0; i < n; i++) r = {a[WIDTH-1], r[WIDTH-1:1]};
        s = (n >= WIDTH) ? |a : |(a & lowmask[WIDTH-1:0]);
      end
      default: begin
        aa = {a, a} >> (n % WIDTH);
        r  = aa[WIDTH-1:0];
      end
    endcase
    if (!STK_EN) s = 1'b0;
    return {s, r};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [1:0] mode, input int n,
                               input logic [WIDTH:0] exp);
    in_data  = a;
    in_mode  = mode;
    in_amt   = SHW'(n);
    in_valid = 1'b1;
    #1;
    for (int t = 0; t < 500 && !in_ready; t++) begin
      @(negedge clk);
      #1;
    end
    if (!in_ready) begin
      nvec++;
      nfail++;
      $display("[TB] FAIL in_ready_timeout: got 0, expected 1 (cycle %0d)", cyc);
    end else begin
      sb.push_back('{exp[WIDTH-1:0], exp[WIDTH], cyc, lat_en});
    end
    @(negedge clk);
  endtask

  task automatic applyRandom();
    logic [63:0]      r;
    logic [1:0]       m;
    int               n;
    r = {$urandom(), $urandom()};
    m = 2'($urandom_range(0, 3));
    n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(WIDTH, 63))
                                    : int'($urandom_range(0, WIDTH - 1));
    applyStimulus(r[WIDTH-1:0], m, n, refShift(r[WIDTH-1:0], m, n));
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && sb.size() != 0; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      nvec++;
      nfail++;
      $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", sb.size());
    end
  endtask

  // Pseudo-random backpressure, changed on the falling edge only.
  initial begin
    forever begin
      @(negedge clk);
      if (bp_en) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: compares each output transfer against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        checkOutput("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            nvec++;
            nfail++;
            $display("[TB] FAIL unexpected_output: got data %h, expected no output", out_data);
          end else begin
            e = sb.pop_front();
            checkOutput("data", 64'(out_data), 64'(e.data));
            checkOutput("sticky", 64'(out_sticky), 64'(e.sticky));
            if (e.chk_lat) checkOutput("latency", 64'(cyc - e.tin), 64'(STAGES));
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [63:0]      r;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = 2'd0;
    in_amt    = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_out_data", 64'(out_data), 64'd0);
    checkOutput("reset_out_sticky", 64'(out_sticky), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] basic modes");
    a = 46'h2AAAAAAAAAAB;
    applyStimulus(a, 2'd0, 4, {1'b0,   46'h2AAAAAAAAAB0});
    applyStimulus(a, 2'd1, 4, {STK_EN, 46'h02AAAAAAAAAA});
    applyStimulus(a, 2'd2, 4, {STK_EN, 46'h3EAAAAAAAAAA});
    applyStimulus(a, 2'd3, 4, {1'b0,   46'h2EAAAAAAAAAA});

    $display("[TB] out-of-range and wrap");
    applyStimulus(46'h1, 2'd1, 63, {STK_EN, 46'h0});
    applyStimulus(46'h200000000000, 2'd2, 50, {STK_EN, 46'h3FFFFFFFFFFF});
    r = {$urandom(), $urandom()};
    b = r[WIDTH-1:0];
    applyStimulus(b, 2'd3, 46, {1'b0, b});
    applyStimulus(b, 2'd3, 47, refShift(b, 2'd3, 1));
    for (int m = 0; m < 4; m++) applyStimulus(b, 2'(m), 0, {1'b0, b});
    in_valid = 1'b0;
    drain();

    $display("[TB] backpressure");
    lat_en = 1'b0;
    bp_en  = 1'b1;
    repeat (8) applyRandom();
    in_valid = 1'b0;
    drain();
    repeat (40) applyRandom();
    in_valid = 1'b0;
    drain();
    bp_en     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);

    $display("[TB] reset mid-flight");
    out_ready = 1'b0;
    applyStimulus(a, 2'd1, 4, refShift(a, 2'd1, 4));
    applyStimulus(a, 2'd0, 9, refShift(a, 2'd0, 9));
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_out_data", 64'(out_data), 64'd0);
    checkOutput("midrst_out_sticky", 64'(out_sticky), 64'd0);
    sb.delete();
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
